// File: rtl/switchless_ctrl.sv
// Supervisory controller around the console-side CIC: button debounce, short/long press split,
// CIC restart sequencing and region select. Optional auto-region retry: SWITCHLESS_AUTOREGION_EN.
//
// state    | meaning
// S_BOOT   | CIC and console held in reset for CIC_RST_CYCLES
// S_RUN    | normal operation, watching button and CIC lockout
// S_PRESS  | button held, timing short vs long press
// S_REGION | long press taken, region advanced, waiting for release
// S_DEAD   | CIC lockout failure, error LED lit until next boot
module switchless_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd1000,
  parameter logic [23:0] LONG_PRESS_CYCLES = 24'd1500000,
  parameter logic [15:0] CIC_RST_CYCLES    = 16'd64,
  parameter logic [1:0]  DEFAULT_REGION    = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       cic_rst_host,
  input  logic       cic_dead,
  output logic       cic_rst,
  output logic       console_rst,
  output logic [1:0] region,
  output logic       pal,
  output logic       jp,
  output logic       led_err
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_RUN    = 3'd1,
    S_PRESS  = 3'd2,
    S_REGION = 3'd3,
    S_DEAD   = 3'd4
  } state_t;

  state_t      state, state_n;
  logic        btn_s1, btn_s2, btn_acc, armed, pressed;
  logic [15:0] db_cnt;
  logic [15:0] boot_cnt;
  logic [23:0] press_cnt;
  logic        dead_q, dead_rise;
  logic        boot_done, long_hit;
  logic        force_rst, region_adv;
  logic [1:0]  region_q;

  // Synchronisers reset to "pressed" so a button held through reset never counts as a
  // press; armed only sets once a genuine release has been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      btn_acc <= 1'b1;
      db_cnt  <= '0;
      armed   <= 1'b0;
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_acc) begin
        db_cnt <= '0;
      end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
        btn_acc <= btn_s2;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
      if (btn_s2 && btn_acc) armed <= 1'b1;
    end
  end

  assign pressed   = armed & ~btn_acc;
  assign dead_rise = cic_dead & ~dead_q;
  assign boot_done = (boot_cnt == CIC_RST_CYCLES - 16'd1);
  assign long_hit  = (press_cnt == LONG_PRESS_CYCLES - 24'd1);

`ifdef SWITCHLESS_AUTOREGION_EN
  logic [1:0] retry_cnt;
  logic       retry_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= 2'd0;
    end else if (state_n == S_PRESS && state != S_PRESS) begin
      retry_cnt <= 2'd0;
    end else if (retry_inc) begin
      retry_cnt <= retry_cnt + 2'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_BOOT;
      boot_cnt  <= '0;
      press_cnt <= '0;
      dead_q    <= 1'b0;
      region_q  <= DEFAULT_REGION;
      led_err   <= 1'b0;
    end else begin
      state  <= state_n;
      dead_q <= cic_dead;

      if (state == S_BOOT && !boot_done) boot_cnt <= boot_cnt + 16'd1;
      else                               boot_cnt <= '0;

      if (state == S_PRESS) begin
        if (press_cnt != LONG_PRESS_CYCLES) press_cnt <= press_cnt + 24'd1;
      end else begin
        press_cnt <= '0;
      end

      if (region_adv) region_q <= (region_q >= 2'd2) ? 2'd0 : region_q + 2'd1;

      if (state_n == S_DEAD && state != S_DEAD)      led_err <= 1'b1;
      else if (state_n == S_BOOT && state != S_BOOT) led_err <= 1'b0;
    end
  end

  always_comb begin
    state_n    = state;
    cic_rst    = 1'b0;
    force_rst  = 1'b0;
    region_adv = 1'b0;
`ifdef SWITCHLESS_AUTOREGION_EN
    retry_inc  = 1'b0;
`endif
    case (state)
      S_BOOT: begin
        cic_rst   = 1'b1;
        force_rst = 1'b1;
        if (boot_done) state_n = S_RUN;
      end
      S_RUN: begin
        if (pressed) begin
          state_n = S_PRESS;
        end else if (dead_rise) begin
`ifdef SWITCHLESS_AUTOREGION_EN
          if (retry_cnt != 2'd3) begin
            region_adv = 1'b1;
            retry_inc  = 1'b1;
            state_n    = S_BOOT;
          end else begin
            state_n = S_DEAD;
          end
`else
          state_n = S_DEAD;
`endif
        end
      end
      S_PRESS: begin
        force_rst = 1'b1;
        if (pressed && long_hit) begin
          region_adv = 1'b1;
          state_n    = S_REGION;
        end else if (!pressed) begin
          state_n = S_BOOT;
        end
      end
      S_REGION: begin
        force_rst = 1'b1;
        if (!pressed) state_n = S_BOOT;
      end
      S_DEAD: begin
        if (pressed) state_n = S_PRESS;
      end
      default: state_n = S_BOOT;
    endcase
  end

  assign console_rst = cic_rst_host | force_rst;
  assign region      = region_q;
  assign pal         = (region_q == 2'd1);
  assign jp          = (region_q == 2'd2);

endmodule

// File: tb/tb_switchless_ctrl.sv
// Scoreboard bench for switchless_ctrl: expected output-change events are queued ahead of
// each stimulus; a negedge monitor pops one per observed change and checks value and dwell.
module tb_switchless_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_n = 1'b1;
  logic       cic_rst_host = 1'b0;
  logic       cic_dead = 1'b0;
  logic       cic_rst, console_rst, pal, jp, led_err;
  logic [1:0] region;

  int total = 0;
  int bad   = 0;

  switchless_ctrl #(
    .DEBOUNCE_CYCLES  (16'd4),
    .LONG_PRESS_CYCLES(24'd50),
    .CIC_RST_CYCLES   (16'd8),
    .DEFAULT_REGION   (2'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .cic_rst_host(cic_rst_host),
    .cic_dead    (cic_dead),
    .cic_rst     (cic_rst),
    .console_rst (console_rst),
    .region      (region),
    .pal         (pal),
    .jp          (jp),
    .led_err     (led_err)
  );

  always #5 clk = ~clk;

  // tuple = {cic_rst, console_rst, led_err, region, pal, jp}; dwell 0 means "don't check"
  typedef struct {
    logic [6:0] tup;
    int         dwell;
  } exp_t;

  exp_t q[$];

  function automatic logic [6:0] mk(input logic c, input logic con, input logic led,
                                    input logic [1:0] r);
    return {c, con, led, r, (r == 2'd1), (r == 2'd2)};
  endfunction

  task automatic exp_ev(input logic c, input logic con, input logic led,
                        input logic [1:0] r, input int dw);
    exp_t e;
    e.tup   = mk(c, con, led, r);
    e.dwell = dw;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int len);
    btn_n = 1'b0;
    cyc(len);
    btn_n = 1'b1;
  endtask

  // Monitor
  int         ncyc = 0;
  int         last_cyc = 0;
  int         ev_idx = 0;
  bit         seen = 1'b0;
  logic [6:0] prev;
  logic [6:0] cur;

  always @(negedge clk) begin
    exp_t e;
    ncyc = ncyc + 1;
    cur  = {cic_rst, console_rst, led_err, region, pal, jp};
    if (!seen || cur != prev) begin
      total = total + 1;
      if (q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_change cyc=%0d got=%b", ncyc, cur);
      end else begin
        e = q.pop_front();
        if (cur != e.tup) begin
          bad = bad + 1;
          $display("FAIL ev%0d tuple got=%b want=%b", ev_idx, cur, e.tup);
        end
        if (e.dwell != 0) begin
          total = total + 1;
          if (ncyc - last_cyc != e.dwell) begin
            bad = bad + 1;
            $display("FAIL ev%0d dwell got=%0d want=%0d", ev_idx, ncyc - last_cyc, e.dwell);
          end
        end
      end
      ev_idx   = ev_idx + 1;
      last_cyc = ncyc;
      prev     = cur;
      seen     = 1'b1;
    end
  end

  initial begin
    logic [1:0] r, rn;

    // Reset values, then 2 reset cycles + 8 boot cycles
    exp_ev(1, 1, 0, 2'd0, 0);
    exp_ev(0, 0, 0, 2'd0, 10);
    cyc(3);
    rst = 1'b0;
    cyc(20);

    // console_rst follows cic_rst_host in S_RUN
    exp_ev(0, 1, 0, 2'd0, 0);
    exp_ev(0, 0, 0, 2'd0, 5);
    cic_rst_host = 1'b1;
    cyc(5);
    cic_rst_host = 1'b0;
    cyc(10);

    // Bouncy short press: bounces rejected, 20-cycle hold -> console reset + CIC restart
    exp_ev(0, 1, 0, 2'd0, 0);
    exp_ev(1, 1, 0, 2'd0, 20);
    exp_ev(0, 0, 0, 2'd0, 8);
    press(3);
    cyc(3);
    press(3);
    cyc(3);
    press(20);
    // cic_dead pulse inside S_BOOT must be ignored
    cyc(8);
    cic_dead = 1'b1;
    cyc(4);
    cic_dead = 1'b0;
    cyc(20);

    // Three long presses: region 0 -> 1 -> 2 -> 0
    for (int i = 0; i < 3; i++) begin
      r  = 2'(i);
      rn = 2'((i + 1) % 3);
      exp_ev(0, 1, 0, r, 0);
      exp_ev(0, 1, 0, rn, 50);
      exp_ev(1, 1, 0, rn, 10);
      exp_ev(0, 0, 0, rn, 8);
      press(60);
      cyc(30);
    end

    // 500-cycle hold: exactly one advance, console reset until release + 8
    exp_ev(0, 1, 0, 2'd0, 0);
    exp_ev(0, 1, 0, 2'd1, 50);
    exp_ev(1, 1, 0, 2'd1, 450);
    exp_ev(0, 0, 0, 2'd1, 8);
    press(500);
    cyc(30);

    // rst mid-press: press discarded, held button ignored until re-pressed
    exp_ev(0, 1, 0, 2'd1, 0);
    exp_ev(1, 1, 0, 2'd0, 0);
    exp_ev(0, 0, 0, 2'd0, 11);
    btn_n = 1'b0;
    cyc(20);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(100);
    btn_n = 1'b1;
    cyc(30);

`ifdef SWITCHLESS_AUTOREGION_EN
    // Auto retries advance region 1, 2, 0, then park in S_DEAD
    for (int i = 0; i < 3; i++) begin
      rn = 2'((i + 1) % 3);
      exp_ev(1, 1, 0, rn, 0);
      exp_ev(0, 0, 0, rn, 8);
      cic_dead = 1'b1;
      cyc(1);
      cic_dead = 1'b0;
      cyc(15);
    end
    exp_ev(0, 0, 1, 2'd0, 0);
    cic_dead = 1'b1;
    cyc(1);
    cic_dead = 1'b0;
    cyc(10);
    exp_ev(1, 1, 0, 2'd0, 0);
    exp_ev(0, 0, 0, 2'd0, 11);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(20);
    // rst during an auto-retry boot restores region and retry count
    exp_ev(1, 1, 0, 2'd1, 0);
    exp_ev(1, 1, 0, 2'd0, 0);
    exp_ev(0, 0, 0, 2'd0, 11);
    cic_dead = 1'b1;
    cyc(1);
    cic_dead = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(20);
    exp_ev(1, 1, 0, 2'd1, 0);
    exp_ev(0, 0, 0, 2'd1, 8);
    cic_dead = 1'b1;
    cyc(1);
    cic_dead = 1'b0;
    cyc(20);
`else
    // Lockout: led_err set, region kept; short press clears it on S_BOOT entry
    exp_ev(0, 0, 1, 2'd0, 0);
    cic_dead = 1'b1;
    cyc(4);
    cic_dead = 1'b0;
    cyc(10);
    exp_ev(0, 1, 1, 2'd0, 0);
    exp_ev(1, 1, 0, 2'd0, 20);
    exp_ev(0, 0, 0, 2'd0, 8);
    press(20);
    cyc(30);
`endif

    cyc(20);
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL pending_events got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
